// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
package wb_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    function automatic logic is_x0(input logic [REG_AW-1:0] rd);
        return rd == '0;
    endfunction
endpackage

// File: rtl/wb_result_queue.sv
// Circular buffer of deferred MD results with kill-by-rd and two rd lookups.
module wb_result_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  wb_entry_t              push_entry,
    input  logic                   pop,
    input  logic                   kill,
    input  logic [REG_AW-1:0]      kill_rd,
    input  logic [REG_AW-1:0]      rs1,
    input  logic [REG_AW-1:0]      rs2,
    output wb_entry_t              head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   match1,
    output logic                   match2
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            // Killed entries keep their slot; only the valid bit drops.
            for (int i = 0; i < DEPTH; i++)
                if (kill && mem[i].rd == kill_rd) mem[i].valid <= 1'b0;
            // Popped slots are cleared so lookups can scan every slot.
            if (pop) begin
                mem[rd_ptr].valid <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].valid && mem[i].rd == rs1) match1 = 1'b1;
            if (mem[i].valid && mem[i].rd == rs2) match2 = 1'b1;
        end
    end
endmodule

// File: rtl/reg_writeback_arbiter.sv
// Register-file write port arbiter: pipeline results win, MD results queue.
// Define WB_STATS_EN to add the saturating COLLIDE_CNT collision counter.
module reg_writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   PIPE_VALID,
    input  logic [REG_AW-1:0]      PIPE_RD,
    input  logic [XLEN-1:0]        PIPE_DATA,
    input  logic                   MD_VALID,
    input  logic [REG_AW-1:0]      MD_RD,
    input  logic [XLEN-1:0]        MD_DATA,
    output logic                   MD_READY,
    input  logic [REG_AW-1:0]      RS1,
    input  logic [REG_AW-1:0]      RS2,
    output logic                   HAZARD1,
    output logic                   HAZARD2,
    output logic                   WRITEENABLE,
    output logic [REG_AW-1:0]      WRITEADDRESS,
    output logic [XLEN-1:0]        WRITEDATA,
    output logic [$clog2(DEPTH):0] QUEUE_COUNT
`ifdef WB_STATS_EN
    ,
    output logic [CNT_W-1:0]       COLLIDE_CNT
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    wb_entry_t         head;
    wb_entry_t         push_entry;
    logic [CW-1:0]     count;
    logic              match1, match2;
    logic              pipe_wr, md_xfer, q_empty, pop, direct, push;
    logic              we_nxt;
    logic [REG_AW-1:0] addr_nxt;
    logic [XLEN-1:0]   data_nxt;

    assign QUEUE_COUNT = count;
    assign q_empty     = count == '0;
    // Registered count only: a same-cycle pop does not open a slot.
    assign MD_READY    = count < FULL;
    assign md_xfer     = MD_VALID && MD_READY;
    assign pipe_wr     = PIPE_VALID && !is_x0(PIPE_RD);
    assign pop         = !pipe_wr && !q_empty;
    assign direct      = md_xfer && !pipe_wr && q_empty;
    assign push        = md_xfer && !direct && !is_x0(MD_RD) &&
                         !(pipe_wr && PIPE_RD == MD_RD);
    assign push_entry  = '{valid: 1'b1, rd: MD_RD, data: MD_DATA};
    assign HAZARD1     = !is_x0(RS1) && match1;
    assign HAZARD2     = !is_x0(RS2) && match2;

    wb_result_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (CLK),
        .reset      (RESET),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill       (pipe_wr),
        .kill_rd    (PIPE_RD),
        .rs1        (RS1),
        .rs2        (RS2),
        .head       (head),
        .count      (count),
        .match1     (match1),
        .match2     (match2)
    );

    always_comb begin
        we_nxt   = 1'b0;
        addr_nxt = PIPE_RD;
        data_nxt = PIPE_DATA;
        if (pipe_wr) begin
            we_nxt = 1'b1;
        end else if (!q_empty) begin
            we_nxt   = head.valid;
            addr_nxt = head.rd;
            data_nxt = head.data;
        end else if (direct) begin
            we_nxt   = !is_x0(MD_RD);
            addr_nxt = MD_RD;
            data_nxt = MD_DATA;
        end
    end

    // Address/data hold their last written value while the strobe is low.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            WRITEENABLE  <= 1'b0;
            WRITEADDRESS <= '0;
            WRITEDATA    <= '0;
        end else begin
            WRITEENABLE <= we_nxt;
            if (we_nxt) begin
                WRITEADDRESS <= addr_nxt;
                WRITEDATA    <= data_nxt;
            end
        end
    end

`ifdef WB_STATS_EN
    always_ff @(posedge CLK) begin
        if (RESET)
            COLLIDE_CNT <= '0;
        else if (push && COLLIDE_CNT != '1)
            COLLIDE_CNT <= COLLIDE_CNT + 1'b1;
    end
`endif
endmodule
